// File: rtl/phase_accumulator.sv
// Fractional phase accumulator for wavetable playback.
//
// On every sample tick while a note is playing, a fixed-point increment
// (integer part: jump, fractional part: remainder / FRAC_MOD) is added to the
// wavetable phase index. The fraction is kept modulo FRAC_MOD, so pitch stays
// exact over arbitrarily long notes.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   enable       1 = note playing; 0 = clear and idle
//   sample_tick  one-cycle strobe, one per output sample
//   jump         integer phase increment per tick
//   remainder    fractional increment numerator, legal range 0..FRAC_MOD-1
//   phase        current wavetable index (registered)
//   phase_valid  one-cycle pulse: phase updated on the previous edge
//   wrap         one-cycle pulse: that update wrapped past 2**PHASE_W-1
//   active       1 while running with a nonzero increment
module phase_accumulator #(
  parameter int unsigned PHASE_W  = 11,
  parameter int unsigned FRAC_MOD = 100000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               sample_tick,
  input  logic [5:0]         jump,
  input  logic [26:0]        remainder,
  output logic [PHASE_W-1:0] phase,
  output logic               phase_valid,
  output logic               wrap,
  output logic               active
);

  localparam int unsigned FullW = PHASE_W + 1;
  localparam logic [27:0] FracModW = 28'(FRAC_MOD);
  localparam logic [26:0] RemMax   = 27'(FRAC_MOD - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e             state_q;
  logic [PHASE_W-1:0] phase_q;
  logic [26:0]        frac_q;
  logic               phase_valid_q;
  logic               wrap_q;
  logic               active_q;

  logic [26:0]      rem_c;
  logic [27:0]      sum;
  logic             carry;
  logic [26:0]      frac_upd;
  logic [FullW-1:0] full;
  logic             inc_nz;

  always_comb begin
    // Out-of-range remainders saturate so frac can never reach FRAC_MOD.
    rem_c    = (remainder >= RemMax + 27'd1) ? RemMax : remainder;
    sum      = {1'b0, frac_q} + {1'b0, rem_c};
    carry    = (sum >= FracModW);
    frac_upd = carry ? 27'(sum - FracModW) : sum[26:0];
    full     = {1'b0, phase_q} + FullW'(jump) + FullW'(carry);
    inc_nz   = (jump != 6'd0) || (remainder != 27'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      phase_q       <= '0;
      frac_q        <= '0;
      phase_valid_q <= 1'b0;
      wrap_q        <= 1'b0;
      active_q      <= 1'b0;
    end else begin
      // Next state is RUN exactly when enable is high, in either state.
      active_q <= enable && inc_nz;
      unique case (state_q)
        StIdle: begin
          phase_q       <= '0;
          frac_q        <= '0;
          phase_valid_q <= 1'b0;
          wrap_q        <= 1'b0;
          if (enable) state_q <= StRun;
        end
        StRun: begin
          if (!enable) begin
            // Clear wins over a coincident tick.
            state_q       <= StIdle;
            phase_q       <= '0;
            frac_q        <= '0;
            phase_valid_q <= 1'b0;
            wrap_q        <= 1'b0;
          end else begin
            phase_valid_q <= sample_tick;
            wrap_q        <= sample_tick && full[PHASE_W];
            if (sample_tick) begin
              phase_q <= full[PHASE_W-1:0];
              frac_q  <= frac_upd;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign phase       = phase_q;
  assign phase_valid = phase_valid_q;
  assign wrap        = wrap_q;
  assign active      = active_q;

endmodule

// File: tb/tb_phase_accumulator.sv
module tb_phase_accumulator;

  localparam int unsigned PhaseW  = 11;
  localparam longint      FracMod = 100000000;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic              sample_tick;
  logic [5:0]        jump;
  logic [26:0]       remainder;
  logic [PhaseW-1:0] phase;
  logic              phase_valid;
  logic              wrap;
  logic              active;

  phase_accumulator #(
    .PHASE_W  (PhaseW),
    .FRAC_MOD (100000000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .sample_tick (sample_tick),
    .jump        (jump),
    .remainder   (remainder),
    .phase       (phase),
    .phase_valid (phase_valid),
    .wrap        (wrap),
    .active      (active)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint ph;
    longint fr;
    bit     pv;
    bit     wr;
    bit     act;
  } exp_t;

  exp_t   sb[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     pv_count;

  // Reference model state
  bit     m_run;
  longint m_phase;
  longint m_frac;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, predict the post-edge outputs, then compare.
  task automatic cycle(input bit r, input bit en, input bit tk,
                       input int j, input longint rm);
    exp_t   e;
    longint rc;
    longint f;
    longint p;
    bit     c;
    rst = r; enable = en; sample_tick = tk;
    jump = 6'(j); remainder = 27'(rm);
    e.pv = 0; e.wr = 0;
    e.act = 0;
    if (r) begin
      m_run = 0; m_phase = 0; m_frac = 0;
    end else if (!m_run || !en) begin
      m_run = en; m_phase = 0; m_frac = 0;
      e.act = en && (j != 0 || rm != 0);
    end else begin
      e.act = (j != 0 || rm != 0);
      if (tk) begin
        rc = (rm >= FracMod) ? FracMod - 1 : rm;
        f  = m_frac + rc;
        c  = (f >= FracMod);
        if (c) f = f - FracMod;
        p  = m_phase + j + (c ? 1 : 0);
        e.wr = (p >= 2048);
        e.pv = 1;
        m_phase = p % 2048;
        m_frac  = f;
      end
    end
    e.ph = m_phase;
    e.fr = m_frac;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("phase", longint'(phase), e.ph);
    check("frac", longint'(dut.frac_q), e.fr);
    check("phase_valid", longint'(phase_valid), longint'(e.pv));
    check("wrap", longint'(wrap), longint'(e.wr));
    check("active", longint'(active), longint'(e.act));
    if (phase_valid) pv_count++;
  endtask

  initial begin
    m_run = 0; m_phase = 0; m_frac = 0;
    rst = 1; enable = 0; sample_tick = 0; jump = 0; remainder = 0;
    @(negedge clk);

    // Reset state
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("rst_phase", longint'(phase), 0);
    check("rst_active", longint'(active), 0);

    // Ticks in IDLE are ignored
    cycle(0, 0, 1, 28, 16000000);
    check("idle_tick_pv", longint'(phase_valid), 0);

    // Test 1: first tick
    cycle(0, 1, 0, 28, 16000000);
    check("t1_active", longint'(active), 1);
    cycle(0, 1, 1, 28, 16000000);
    check("t1_phase", longint'(phase), 28);
    check("t1_pv", longint'(phase_valid), 1);
    check("t1_wrap", longint'(wrap), 0);

    // Test 2: seven back-to-back ticks from 0
    for (int i = 0; i < 5; i++) cycle(0, 1, 1, 28, 16000000);
    check("t2_phase6", longint'(phase), 168);
    check("t2_frac6", longint'(dut.frac_q), 96000000);
    cycle(0, 1, 1, 28, 16000000);
    check("t2_phase7", longint'(phase), 197);
    check("t2_frac7", longint'(dut.frac_q), 12000000);

    // Test 3: wrap past 2047
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 63, 21706256);
    for (int i = 0; i < 32; i++) cycle(0, 1, 1, 63, 21706256);
    check("t3_phase32", longint'(phase), 2022);
    check("t3_wrap32", longint'(wrap), 0);
    cycle(0, 1, 1, 63, 21706256);
    check("t3_phase33", longint'(phase), 38);
    check("t3_wrap33", longint'(wrap), 1);
    cycle(0, 1, 0, 63, 21706256);
    check("t3_wrap_after", longint'(wrap), 0);
    check("t3_pv_after", longint'(phase_valid), 0);

    // Test 4: rest note holds phase but still pulses phase_valid
    pv_count = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 1, 0, 0);
      cycle(0, 1, 0, 0, 0);
    end
    check("t4_phase", longint'(phase), 38);
    check("t4_frac", longint'(dut.frac_q), 16306448);
    check("t4_pulses", longint'(pv_count), 5);
    check("t4_active", longint'(active), 0);

    // Test 5: note change is phase-continuous; tick with enable=0 clears
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 28, 16000000);
    check("t5_cont_phase", longint'(phase), 122);
    cycle(0, 0, 1, 28, 16000000);
    check("t5_clr_phase", longint'(phase), 0);
    check("t5_clr_pv", longint'(phase_valid), 0);
    check("t5_idle", longint'(dut.state_q), 0);
    cycle(0, 1, 0, 40, 5);
    for (int i = 0; i < 4; i++) cycle(0, 1, 1, 40, 5);
    cycle(1, 1, 1, 40, 5);
    check("t5_rst_phase", longint'(phase), 0);
    check("t5_rst_pv", longint'(phase_valid), 0);
    check("t5_rst_wrap", longint'(wrap), 0);
    check("t5_rst_active", longint'(active), 0);

    // Test 6: illegal remainder saturates
    cycle(0, 1, 0, 0, 134217727);
    cycle(0, 1, 1, 0, 134217727);
    check("t6_frac1", longint'(dut.frac_q), 99999999);
    check("t6_phase1", longint'(phase), 0);
    cycle(0, 1, 1, 0, 134217727);
    check("t6_frac2", longint'(dut.frac_q), 99999998);
    check("t6_phase2", longint'(phase), 1);
    check("t6_active", longint'(active), 1);

    check("sb_empty", longint'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
